// File: rtl/nibble_serial_pkg.sv
// Shared types for the nibble-serial adder sequencer.
// Holds the FSM encoding and the slice width that the datapath steps through.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ns_state_t;

endpackage

// File: rtl/ripple_carry_adder_4_bit.sv
// 4-bit ripple-carry adder: combinational, zero latency.
// It has no handshake, so backpressure does not apply.
module ripple_carry_adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  always_comb begin
    logic [4:0] c;
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/sub on one 4-bit adder, one nibble per clock. Valid rises NIBBLES edges after accept.
// The input is blocked (in_ready=0) until the result is taken; the result is held while out_ready=0.
module nibble_serial_adder_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_Sum,
  output logic             out_Cout,
  output logic             out_V
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int SEL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  ns_state_t        state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] nib_idx;

  logic [SEL_W-1:0]    base;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  // Bit offset of the active nibble, nib_idx * 4.
  assign base  = SEL_W'({nib_idx, 2'b00});
  assign nib_a = a_reg[base +: NIBBLE_W];
  assign nib_b = b_reg[base +: NIBBLE_W];

  ripple_carry_adder_4_bit u_adder (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_reg),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      nib_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_A;
            // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
            b_reg     <= in_B ^ {WIDTH{in_sub}};
            carry_reg <= in_sub ? 1'b1 : in_Cin;
            nib_idx   <= '0;
            sum_reg   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: NIBBLE_W] <= nib_sum;
          carry_reg                 <= nib_cout;
          if (nib_idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_Sum   = sum_reg;
  assign out_Cout  = carry_reg;
  assign out_V     = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at WIDTH 16, 8 and 4; sel picks the active instance.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        in_Cin;
  logic        in_sub;
  logic        out_ready;
  int          sel;

  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, c16, v16;
  logic [15:0] s16;
  logic        iv8, ir8, ov8, c8, v8;
  logic [7:0]  s8;
  logic        iv4, ir4, ov4, c4, v4;
  logic [3:0]  s4;

  assign iv16 = in_valid && (sel == 0);
  assign iv8  = in_valid && (sel == 1);
  assign iv4  = in_valid && (sel == 2);

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_A(in_A), .in_B(in_B), .in_Cin(in_Cin), .in_sub(in_sub),
    .out_valid(ov16), .out_ready(out_ready), .out_Sum(s16), .out_Cout(c16), .out_V(v16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_A(in_A[7:0]), .in_B(in_B[7:0]), .in_Cin(in_Cin), .in_sub(in_sub),
    .out_valid(ov8), .out_ready(out_ready), .out_Sum(s8), .out_Cout(c8), .out_V(v8)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_A(in_A[3:0]), .in_B(in_B[3:0]), .in_Cin(in_Cin), .in_sub(in_sub),
    .out_valid(ov4), .out_ready(out_ready), .out_Sum(s4), .out_Cout(c4), .out_V(v4)
  );

  logic        obs_in_ready, obs_out_valid, obs_cout, obs_v;
  logic [15:0] obs_sum;

  always_comb begin
    obs_in_ready  = ir16;
    obs_out_valid = ov16;
    obs_sum       = s16;
    obs_cout      = c16;
    obs_v         = v16;
    if (sel == 1) begin
      obs_in_ready = ir8; obs_out_valid = ov8; obs_sum = {8'h00, s8}; obs_cout = c8; obs_v = v8;
    end else if (sel == 2) begin
      obs_in_ready = ir4; obs_out_valid = ov4; obs_sum = {12'h000, s4}; obs_cout = c4; obs_v = v4;
    end
  end

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic int width_of(int s);
    return (s == 0) ? 16 : ((s == 1) ? 8 : 4);
  endfunction

  // Reference: whole-word arithmetic on the masked operands.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    logic [15:0] mask, am, bb, s;
    logic [16:0] full;
    exp_t        e;
    mask   = (w == 16) ? 16'hFFFF : ((16'h0001 << w) - 16'h0001);
    am     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + {16'h0000, (sub ? 1'b1 : cin)};
    s      = full[15:0] & mask;
    e.sum  = s;
    e.cout = full[w];
    e.v    = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic start_op(int s, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    sel      = s;
    in_A     = a;
    in_B     = b;
    in_Cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    sb.push_back(model(width_of(s), a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_A     = 16'($urandom);
    in_B     = 16'($urandom);
    in_Cin   = 1'($urandom);
    in_sub   = 1'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (obs_out_valid !== 1'b1) begin
      if (n >= 40) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++; if (obs_in_ready !== 1'b1) $display("FAIL reset_in_ready w%0d got %b want 1", width_of(s), obs_in_ready); else passed++;
      total++; if (obs_out_valid !== 1'b0) $display("FAIL reset_out_valid w%0d got %b want 0", width_of(s), obs_out_valid); else passed++;
      total++; if ({obs_sum, obs_cout, obs_v} !== 18'h0) $display("FAIL reset_outputs w%0d got sum=%h c=%b v=%b want 0", width_of(s), obs_sum, obs_cout, obs_v); else passed++;
    end
  endtask

  task automatic test_add();
    int n; bit to; exp_t e;
    start_op(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    wait_valid(n, to);
    total++; if (to || n != 4) $display("FAIL add_latency got %0d edges after accept (timeout=%0d) want 4", n, to); else passed++;
    e = sb.pop_front();
    total++; if (obs_sum !== 16'h2201 || obs_sum !== e.sum) $display("FAIL add_sum got %h want 2201", obs_sum); else passed++;
    total++; if (obs_cout !== e.cout || obs_v !== e.v) $display("FAIL add_flags got c=%b v=%b want c=%b v=%b", obs_cout, obs_v, e.cout, e.v); else passed++;
    finish_op();
  endtask

  task automatic test_carry_ripple();
    exp_t e;
    start_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (dut16.carry_reg !== 1'b1) $display("FAIL ripple_carry edge%0d got %b want 1", i, dut16.carry_reg); else passed++;
    end
    total++; if (obs_out_valid !== 1'b1) $display("FAIL ripple_valid got %b want 1", obs_out_valid); else passed++;
    e = sb.pop_front();
    total++; if (obs_sum !== 16'h0000 || obs_sum !== e.sum) $display("FAIL ripple_sum got %h want 0000", obs_sum); else passed++;
    total++; if (obs_cout !== 1'b1 || obs_v !== 1'b0) $display("FAIL ripple_flags got c=%b v=%b want c=1 v=0", obs_cout, obs_v); else passed++;
    finish_op();
  endtask

  task automatic test_subtract();
    int n; bit to; exp_t e;
    start_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to || obs_sum !== 16'h7FFF || obs_sum !== e.sum) $display("FAIL sub_ovf_sum got %h want 7fff", obs_sum); else passed++;
    total++; if (obs_cout !== 1'b1 || obs_v !== 1'b1) $display("FAIL sub_ovf_flags got c=%b v=%b want c=1 v=1", obs_cout, obs_v); else passed++;
    finish_op();
    start_op(0, 16'h0003, 16'h0005, 1'b1, 1'b1);
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to || obs_sum !== 16'hFFFE || obs_sum !== e.sum) $display("FAIL sub_neg_sum got %h want fffe", obs_sum); else passed++;
    total++; if (obs_cout !== 1'b0 || obs_v !== 1'b0) $display("FAIL sub_neg_flags got c=%b v=%b want c=0 v=0", obs_cout, obs_v); else passed++;
    finish_op();
  endtask

  task automatic test_backpressure();
    int n; bit to; exp_t e;
    start_op(0, 16'hA5A5, 16'h1111, 1'b1, 1'b0);
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to) $display("FAIL bp_wait got timeout want valid"); else passed++;
    for (int i = 0; i < 10; i++) begin
      in_A      = 16'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if ({obs_sum, obs_cout, obs_v} !== {e.sum, e.cout, e.v} || obs_out_valid !== 1'b1)
        $display("FAIL bp_hold cyc%0d got sum=%h c=%b v=%b ov=%b want sum=%h c=%b v=%b ov=1", i, obs_sum, obs_cout, obs_v, obs_out_valid, e.sum, e.cout, e.v);
      else passed++;
      total++; if (obs_in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d got %b want 0", i, obs_in_ready); else passed++;
    end
    in_A = 16'h0F0F; in_B = 16'h00F1; in_Cin = 1'b0; in_sub = 1'b0;
    sb.push_back(model(16, 16'h0F0F, 16'h00F1, 1'b0, 1'b0));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", obs_in_ready, obs_out_valid); else passed++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (obs_in_ready !== 1'b0) $display("FAIL bp_accept_next got ir=%b want 0", obs_in_ready); else passed++;
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to || n != 4) $display("FAIL bp_next_latency got %0d (timeout=%0d) want 4", n, to); else passed++;
    total++; if (obs_sum !== 16'h1000 || obs_sum !== e.sum) $display("FAIL bp_next_sum got %h want 1000", obs_sum); else passed++;
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int n; bit to; bit seen; exp_t e;
    start_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    total++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) $display("FAIL midrst_state got ir=%b ov=%b want ir=1 ov=0", obs_in_ready, obs_out_valid); else passed++;
    total++; if ({obs_sum, obs_cout, obs_v} !== 18'h0) $display("FAIL midrst_outputs got sum=%h c=%b v=%b want 0", obs_sum, obs_cout, obs_v); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL midrst_no_valid got a valid pulse want none"); else passed++;
    start_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to || obs_sum !== 16'h0002 || obs_sum !== e.sum) $display("FAIL midrst_follow_sum got %h want 0002", obs_sum); else passed++;
    finish_op();
  endtask

  task automatic test_width4();
    int n; bit to; exp_t e;
    start_op(2, 16'h0009, 16'h0008, 1'b1, 1'b0);
    wait_valid(n, to);
    e = sb.pop_front();
    total++; if (to || n != 1) $display("FAIL w4_latency got %0d (timeout=%0d) want 1", n, to); else passed++;
    total++; if (obs_sum !== 16'h0002 || obs_sum !== e.sum) $display("FAIL w4_sum got %h want 2", obs_sum); else passed++;
    total++; if (obs_cout !== 1'b1 || obs_v !== 1'b1) $display("FAIL w4_flags got c=%b v=%b want c=1 v=1", obs_cout, obs_v); else passed++;
    finish_op();
  endtask

  task automatic test_random();
    int n; bit to; exp_t e;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 200; k++) begin
        start_op(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_valid(n, to);
        e = sb.pop_front();
        total++; if (to || n != width_of(s) / 4) $display("FAIL rand_latency w%0d op%0d got %0d want %0d", width_of(s), k, n, width_of(s) / 4); else passed++;
        total++; if ({obs_sum, obs_cout, obs_v} !== {e.sum, e.cout, e.v})
          $display("FAIL rand_result w%0d op%0d got sum=%h c=%b v=%b want sum=%h c=%b v=%b", width_of(s), k, obs_sum, obs_cout, obs_v, e.sum, e.cout, e.v);
        else passed++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        finish_op();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_A      = '0;
    in_B      = '0;
    in_Cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    sel       = 0;
    @(negedge clk);
    test_reset();
    test_add();
    test_carry_ripple();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
